// File: rtl/mips_div_unit.sv
// -----------------------------------------------------------------------------
// mips_div_unit
//
// Iterative restoring divider for the MIPS DIV/DIVU instructions. It works on
// operand magnitudes, produces one quotient bit per clock, and then applies the
// sign fix-up in a final cycle. The result feeds HI (remainder) and LO
// (quotient). The EX stage stalls while busy is high.
//
// Timing: start is sampled in IDLE at edge T0, the restoring steps run on edges
// T0+1 .. T0+WIDTH, and done pulses after edge T0+WIDTH+1. busy is high for
// WIDTH+1 cycles.
//
// Optional build macro:
//   MIPS_DIV_FAST_ZERO_EN - a zero divisor skips the restoring steps, so done
//                           follows edge T0+1. The results are unchanged.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        operation request, sampled only in IDLE
//   is_signed    1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend     rs operand, sampled with start
//   divisor      rt operand, sampled with start
//   busy         operation in progress (EX stall request)
//   done         one-cycle completion pulse
//   quotient     result to LO, held until the next completion or reset
//   remainder    result to HI, held until the next completion or reset
//   div_by_zero  divisor was zero for the completed operation (held)
// -----------------------------------------------------------------------------
module mips_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] rem;        // partial remainder
    logic [WIDTH-1:0] dq;         // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvsr;       // divisor magnitude
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             dvsr_zero;

    // Operand magnitudes. A negative minimum value negates to itself. Read as
    // unsigned, that value is the correct magnitude 2^(WIDTH-1).
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic             fast_zero;

    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];
    assign dividend_abs = dividend_neg ? -dividend : dividend;
    assign divisor_abs  = divisor_neg  ? -divisor  : divisor;

`ifdef MIPS_DIV_FAST_ZERO_EN
    assign fast_zero = (divisor == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // One restoring step. The shifted remainder needs WIDTH+1 bits because
    // rem < dvsr <= 2^WIDTH-1. The trial result always lies in
    // (-2^WIDTH, 2^WIDTH), so its bit WIDTH is an exact sign bit.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           trial_ok;

    assign shifted  = {rem, dq[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr};
    assign trial_ok = ~trial[WIDTH];

    assign busy = (state != S_IDLE);

    // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = fast_zero ? S_FIN : S_CALC;
            S_CALC:  if (cnt == LAST_STEP) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments, so every register samples pre-edge values and there is no ordering race.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem         <= '0;
            dq          <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dvsr_zero   <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvsr      <= divisor_abs;
                        q_neg     <= dividend_neg ^ divisor_neg;
                        r_neg     <= dividend_neg;
                        dvsr_zero <= (divisor == '0);
                        cnt       <= '0;
                        if (fast_zero) begin
                            // Preload the state the restoring loop would
                            // reach for a zero divisor: all-ones quotient,
                            // remainder equal to the dividend magnitude.
                            rem <= dividend_abs;
                            dq  <= '1;
                        end else begin
                            rem <= '0;
                            dq  <= dividend_abs;
                        end
                    end
                end
                S_CALC: begin
                    rem <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dq  <= {dq[WIDTH-2:0], trial_ok};
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIN: begin
                    // With a zero divisor the quotient stays all ones. The
                    // remainder fix-up still runs, which restores the
                    // original signed dividend.
                    quotient    <= (q_neg && !dvsr_zero) ? -dq : dq;
                    remainder   <= r_neg ? -rem : rem;
                    div_by_zero <= dvsr_zero;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_div_unit
//
// Self-checking bench for mips_div_unit (WIDTH = 32). A cycle-level model
// computes the results with plain integer division and tracks when each
// accepted operation must complete. A compare process checks every DUT output
// against the model on each falling edge. Directed operations also check
// hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_mips_div_unit;

    localparam int W = 32;
`ifdef MIPS_DIV_FAST_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = W + 1;
`endif
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    mips_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    // MIPS semantics: truncating division; the remainder takes the dividend's
    // sign. The signed case is done in 64 bits, so -2^31 / -1 wraps to
    // 0x80000000 when truncated.
    function automatic res_t model_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   res;
        longint sa;
        longint sb;
        if (b == '0) begin
            res.q = '1;
            res.r = a;
            res.z = 1'b1;
        end else if (sgn) begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            res.q = W'(sa / sb);
            res.r = W'(sa % sb);
            res.z = 1'b0;
        end else begin
            res.q = a / b;
            res.r = a % b;
            res.z = 1'b0;
        end
        return res;
    endfunction

    int   m_cnt  = 0;     // cycles until the pending op completes (0 = idle)
    logic m_done = 1'b0;
    res_t m_out  = '0;    // currently held results
    res_t m_pend = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_out  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_out  <= m_pend;
                end
            end else if (start) begin
                m_pend <= model_div(is_signed, dividend, divisor);
                m_cnt  <= (divisor == '0) ? ZERO_LAT : LAT;
            end
        end
    end

    // Compare process: every output on every cycle after the first edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy",        busy,        (m_cnt != 0));
            check("done",        done,        m_done);
            check("quotient",    quotient,    m_out.q);
            check("remainder",   remainder,   m_out.r);
            check("div_by_zero", div_by_zero, m_out.z);
        end
    end

    // --------------------------------------------------------------- driver
    // All tasks start and end 1 ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        step();
        start     = 1'b0;
    endtask

    // Counts edges after the start-sample edge until done, and counts the
    // cycles busy is seen high, including the cycle right after the sample edge.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && edges < 100) begin
            step();
            edges++;
            if (busy) busy_cyc++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic ez);
        int edges;
        int bc;
        issue(sgn, a, b);
        wait_done(edges, bc);
        check({name, ".latency"}, edges, exp_lat);
        check({name, ".busy_cycles"}, bc, exp_lat);
        check({name, ".q"}, quotient, eq);
        check({name, ".r"}, remainder, er);
        check({name, ".dbz"}, div_by_zero, ez);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int edges;
        int bc;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) step();
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.q",    quotient, 0);
        check("reset.r",    remainder, 0);
        check("reset.dbz",  div_by_zero, 0);
        rst_n = 1'b1;
        step();

        // Basic unsigned and signed division.
        run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          LAT, 32'd14,         32'd2,          1'b0);
        run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          LAT, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_op("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  LAT, 32'hFFFF_FFFD,  32'd1,          1'b0);
        // Overflow and extreme operands.
        run_op("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  LAT, 32'h8000_0000,  32'd0,          1'b0);
        run_op("divu_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          LAT, 32'hFFFF_FFFF,  32'd0,          1'b0);
        run_op("divu_big",    1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  LAT, 32'd0,          32'hFFFF_FFFE,  1'b0);
        run_op("divu_half",   1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  LAT, 32'd1,          32'h7FFF_FFFE,  1'b0);
        run_op("div_0_m5",    1'b1, 32'd0,          32'hFFFF_FFFB,  LAT, 32'd0,          32'd0,          1'b0);
        // Divide by zero.
        run_op("divu_5_0",    1'b0, 32'd5,          32'd0,          ZERO_LAT, 32'hFFFF_FFFF, 32'd5,      1'b1);
        run_op("div_m9_0",    1'b1, 32'hFFFF_FFF7,  32'd0,          ZERO_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1);
        run_op("div_min_0",   1'b1, 32'h8000_0000,  32'd0,          ZERO_LAT, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("divu_9_3",    1'b0, 32'd9,          32'd3,          LAT, 32'd3,          32'd0,          1'b0);

        // A start during busy is ignored. A start in the done cycle is accepted.
        issue(1'b0, 32'd50, 32'd4);
        repeat (9) step();
        issue(1'b0, 32'd999, 32'd1);
        wait_done(edges, bc);
        check("ignored_start.q", quotient, 32'd12);
        check("ignored_start.r", remainder, 32'd2);
        check("done_cycle.done", done, 1);
        run_op("b2b_20_3",    1'b0, 32'd20,         32'd3,          LAT, 32'd6,          32'd2,          1'b0);

        // Reset in the middle of an operation.
        issue(1'b0, 32'd12345, 32'd17);
        repeat (13) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.q",    quotient, 0);
        check("abort.r",    remainder, 0);
        check("abort.dbz",  div_by_zero, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            check("abort.no_done", done, 0);
        end
        run_op("post_reset",  1'b1, 32'hFFFF_FF9C,  32'd7,          LAT, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
